// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester, response and divider signals of the shared-divider arbiter
interface div_arbiter_if #(parameter int WIDTH = 32);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_opA0;
  logic [WIDTH-1:0] req_opB0;
  logic [WIDTH-1:0] req_opA1;
  logic [WIDTH-1:0] req_opB1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_exception;
  logic [WIDTH-1:0] div_operandA;
  logic [WIDTH-1:0] div_operandB;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] div_result;
  logic             div_resultRDY;
  modport slave (
    input  req_valid, req_opA0, req_opB0, req_opA1, req_opB1, rsp_ready, div_result, div_resultRDY,
    output req_ready, rsp_valid, rsp_result, rsp_exception, div_operandA, div_operandB, ctrl_DIV
  );
  modport master (
    output req_valid, req_opA0, req_opB0, req_opA1, req_opB1, rsp_ready, div_result, div_resultRDY,
    input  req_ready, rsp_valid, rsp_result, rsp_exception, div_operandA, div_operandB, ctrl_DIV
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider between two requesters
module div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input logic          clock,
  input logic          reset,
  div_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d, tag_q, tag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic             exc_q, exc_d;
  logic             grant, accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  assign grant  = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);
  assign accept = (state_q == IDLE) && |bus.req_valid;
  assign sel_a  = grant ? bus.req_opA1 : bus.req_opA0;
  assign sel_b  = grant ? bus.req_opB1 : bus.req_opB0;
  assign bus.req_ready     = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid     = (state_q == RESP) ? {tag_q, ~tag_q} : 2'b00;
  assign bus.rsp_result    = res_q;
  assign bus.rsp_exception = exc_q;
  assign bus.div_operandA  = opa_q;
  assign bus.div_operandB  = opb_q;
  assign bus.ctrl_DIV      = state_q == ISSUE;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: if (accept) begin
        opa_d  = sel_a;
        opb_d  = sel_b;
        last_d = grant;
        tag_d  = grant;
        if (sel_b == '0) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = RESP;
        end else state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // first WAIT cycle (cnt_q==0) blanks the divider's stale RDY
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0 && bus.div_resultRDY) begin
          res_d   = bus.div_result;
          exc_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = bus.rsp_ready[tag_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tag_q   <= 1'b0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed and random transactions against a divider model and request-level reference
module tb_div_arbiter;
  localparam int W  = 32;
  localparam int TO = 40;
  logic clock = 1'b0;
  logic reset;
  int vecs = 0;
  int miss = 0;
  int m_dly = -1;
  bit m_stale = 1'b0;
  bit m_last = 1'b1;
  int t = 0;
  bit act = 1'b0;
  logic [W-1:0] q;
  always #5 clock = ~clock;
  div_arbiter_if #(.WIDTH(W)) bus();
  div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
  // divider model: RDY pulse m_dly cycles after the ctrl_DIV cycle, optional stale RDY one cycle after start
  always @(negedge clock) begin
    if (reset) act = 1'b0;
    else if (bus.ctrl_DIV) begin
      act = 1'b1;
      t = 0;
      q = (bus.div_operandB == '0) ? '0 : W'($signed(bus.div_operandA) / $signed(bus.div_operandB));
    end else if (act) t++;
    bus.div_resultRDY = act && ((m_dly >= 0 && t == m_dly) || (m_stale && t == 1));
    bus.div_result    = (act && t == m_dly) ? q : 32'hDEAD_BEEF;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic [1:0] v, input logic [W-1:0] a0, b0, a1, b1,
                      input int dly, input bit stale, input int stall);
    logic g;
    logic [1:0] oh;
    logic [W-1:0] ea, eb, er;
    logic ee;
    int rc;
    g = (v == 2'b11) ? ~m_last : v[1];
    m_last = g;
    oh = g ? 2'b10 : 2'b01;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    if (eb == '0) begin rc = 1; er = '0; ee = 1'b1; end
    else if (dly >= 2 && dly <= TO) begin rc = dly + 2; er = W'($signed(ea) / $signed(eb)); ee = 1'b0; end
    else begin rc = TO + 2; er = '0; ee = 1'b1; end
    m_dly = dly;
    m_stale = stale;
    bus.req_valid = v;
    bus.req_opA0 = a0; bus.req_opB0 = b0;
    bus.req_opA1 = a1; bus.req_opB1 = b1;
    #1;
    chk("req_ready", {62'd0, bus.req_ready}, {62'd0, oh});
    @(negedge clock);
    bus.req_valid = 2'b00;
    for (int c = 1; c <= rc; c++) begin
      if (c > 1) @(negedge clock);
      chk("ctrl_DIV", {63'd0, bus.ctrl_DIV}, {63'd0, (c == 1 && eb != '0)});
      chk("rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, (c == rc) ? oh : 2'b00});
      chk("operandA", {32'd0, bus.div_operandA}, {32'd0, ea});
      chk("operandB", {32'd0, bus.div_operandB}, {32'd0, eb});
    end
    chk("rsp_result", {32'd0, bus.rsp_result}, {32'd0, er});
    chk("rsp_exception", {63'd0, bus.rsp_exception}, {63'd0, ee});
    bus.rsp_ready = ~oh;
    repeat (stall) begin
      @(negedge clock);
      chk("stall_valid", {62'd0, bus.rsp_valid}, {62'd0, oh});
      chk("stall_result", {32'd0, bus.rsp_result}, {32'd0, er});
    end
    bus.rsp_ready = oh;
    @(negedge clock);
    bus.rsp_ready = 2'b00;
    chk("rsp_done", {62'd0, bus.rsp_valid}, 64'd0);
  endtask
  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;
    reset = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_opA0 = '0; bus.req_opB0 = '0; bus.req_opA1 = '0; bus.req_opB1 = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("rst_ctrl_DIV", {63'd0, bus.ctrl_DIV}, 64'd0);
    chk("rst_result", {32'd0, bus.rsp_result}, 64'd0);
    chk("rst_operandA", {32'd0, bus.div_operandA}, 64'd0);
    xact(2'b01, 32'd100, 32'd7, 32'd0, 32'd0, 33, 1'b0, 0);
    xact(2'b10, 32'd0, 32'd0, 32'd5, 32'd0, 10, 1'b0, 0);
    repeat (4) xact(2'b11, -32'sd20, 32'sd3, -32'sd20, 32'sd3, 5, 1'b0, 0);
    xact(2'b01, 32'd77, 32'd5, 32'd0, 32'd0, -1, 1'b0, 1);
    xact(2'b10, 32'd0, 32'd0, 32'd81, 32'd9, 7, 1'b1, 0);
    xact(2'b01, 32'd50, 32'd5, 32'd0, 32'd0, 2, 1'b0, 0);
    xact(2'b01, 32'd60, 32'd5, 32'd0, 32'd0, TO, 1'b0, 0);
    xact(2'b10, 32'd0, 32'd0, 32'd60, 32'd5, TO + 1, 1'b0, 0);
    for (int i = 0; i < 14; i++) begin
      ra0 = $urandom >> 1; if ($urandom % 2) ra0 = -ra0;
      ra1 = $urandom >> 1; if ($urandom % 2) ra1 = -ra1;
      rb0 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 1000));
      rb1 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 1000));
      if ($urandom % 2) rb0 = -rb0;
      if ($urandom % 2) rb1 = -rb1;
      xact(2'($urandom_range(1, 3)), ra0, rb0, ra1, rb1, $urandom_range(2, TO + 3),
           1'($urandom % 2), $urandom_range(0, 3));
    end
    m_dly = -1; m_stale = 1'b0;
    bus.req_valid = 2'b01; bus.req_opA0 = 32'd9; bus.req_opB0 = 32'd2;
    @(negedge clock);
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_last = 1'b1;
    chk("mid_rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_ctrl_DIV", {63'd0, bus.ctrl_DIV}, 64'd0);
    chk("mid_rst_operandA", {32'd0, bus.div_operandA}, 64'd0);
    chk("mid_rst_operandB", {32'd0, bus.div_operandB}, 64'd0);
    chk("mid_rst_result", {32'd0, bus.rsp_result}, 64'd0);
    chk("mid_rst_exception", {63'd0, bus.rsp_exception}, 64'd0);
    chk("mid_rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    xact(2'b11, 32'd90, 32'd4, 32'd33, 32'd3, 12, 1'b0, 5);
    xact(2'b11, 32'd90, 32'd4, 32'd33, 32'd3, 3, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
